// File: rtl/bist_ctrl.sv
// ---------------------------------------------------------------------------
// bist_ctrl -- BIST sequencer for the JTAG test logic.
//
// A start request latches the 13-bit configuration word into a shadow
// register. The block then emits a maximal-length 8-bit LFSR pattern stream
// toward the device under test. Each returned response is folded into an
// 8-bit MISR signature, which is compared against an expected value.
//
// Ports
//   CLK            clock, all state updates on the rising edge
//   RST            synchronous, active-high reset
//   BIST_CONF_REG  [0] mode (0 preset, 1 user), [4:1] preset N, [12:5] user L
//   START / ABORT  sequencing requests from the TAP decode (ABORT wins)
//   EXP_SIG        expected signature
//   DUT_RESP       response from the DUT, LATENCY cycles after its pattern
//   PATTERN        current LFSR pattern, live while PAT_VALID=1
//   PAT_VALID      PATTERN is a live test vector this cycle
//   BUSY           high in LOAD, RUN and DRAIN
//   DONE           test complete, signature final
//   SIGNATURE      MISR register
//   PASS           DONE & (SIGNATURE == EXP_SIG), combinational
//
// Parameter
//   LATENCY        pattern-to-response delay in cycles, legal 1..4
// ---------------------------------------------------------------------------
module bist_ctrl #(
  parameter int LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [12:0] BIST_CONF_REG,
  input  logic        START,
  input  logic        ABORT,
  input  logic [7:0]  EXP_SIG,
  input  logic [7:0]  DUT_RESP,
  output logic [7:0]  PATTERN,
  output logic        PAT_VALID,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  SIGNATURE,
  output logic        PASS
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // One step of the x^8+x^6+x^5+x^4+1 shift register. The LFSR and the MISR
  // share this polynomial, so the pattern stream has a period of 255.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  state_t              state_q, state_d;
  logic [12:0]         conf_q, conf_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [7:0]          misr_q, misr_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [LATENCY-1:0]  pipe_q, pipe_d;
  logic                pat_vld_q, pat_vld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Configuration decode from the shadow copy. The live BIST_CONF_REG is
  // read only at the moment of a start.
  logic       conf_mode;
  logic [3:0] conf_n;
  logic [7:0] conf_l;
  logic [8:0] run_len;
  logic [7:0] run_seed;
  logic       resp_vld;

  assign conf_mode = conf_q[0];
  assign conf_n    = conf_q[4:1];
  assign conf_l    = conf_q[12:5];

  // Preset mode runs 16*(N+1) patterns. In user mode L=0 encodes 256, which
  // is why the counter is 9 bits wide.
  always_comb begin
    run_len  = 9'd0;
    run_seed = 8'h01;
    if (conf_mode) begin
      run_len  = (conf_l == 8'd0) ? 9'd256 : {1'b0, conf_l};
      run_seed = 8'h01;
    end else begin
      run_len  = {1'b0, conf_n, 4'b0000} + 9'd16;
      run_seed = {4'h5, conf_n};
    end
  end

  // PAT_VALID delayed by LATENCY cycles marks the cycle in which DUT_RESP
  // carries the response to a live pattern.
  assign resp_vld = pipe_q[LATENCY-1];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    conf_d  = conf_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;

    pipe_d[0] = pat_vld_q;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end

    if (resp_vld) begin
      misr_d = lfsr_step(misr_q) ^ DUT_RESP;
    end

    case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          conf_d  = BIST_CONF_REG;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        lfsr_d  = run_seed;
        misr_d  = 8'h00;
        cnt_d   = run_len;
        pipe_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        lfsr_d = lfsr_step(lfsr_q);
        cnt_d  = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          // Last pattern goes out this cycle. Reload the counter with the
          // pipe depth so DRAIN waits for the final response.
          cnt_d   = 9'(LATENCY);
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          cnt_d   = 9'd0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (START) begin
          conf_d  = BIST_CONF_REG;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // ABORT overrides everything except IDLE. The signature freezes at its
    // partial value and the responses still in flight are discarded.
    if (ABORT && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      conf_d  = conf_q;
      misr_d  = misr_q;
      cnt_d   = 9'd0;
      pipe_d  = '0;
    end
  end

  // Outputs are registered from the next state, so they change in the same
  // cycle as the state they describe.
  always_comb begin
    pat_vld_d = (state_d == S_RUN);
    busy_d    = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      conf_q    <= '0;
      lfsr_q    <= '0;
      misr_q    <= '0;
      cnt_q     <= '0;
      pipe_q    <= '0;
      pat_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      conf_q    <= conf_d;
      lfsr_q    <= lfsr_d;
      misr_q    <= misr_d;
      cnt_q     <= cnt_d;
      pipe_q    <= pipe_d;
      pat_vld_q <= pat_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign PATTERN   = lfsr_q;
  assign PAT_VALID = pat_vld_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign SIGNATURE = misr_q;
  assign PASS      = done_q && (misr_q == EXP_SIG);

endmodule

// File: tb/tb_bist_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bist_ctrl -- self-checking bench for bist_ctrl (LATENCY = 1).
//
// DUT_RESP is a loopback: PATTERN delayed one cycle, XORed with a per-test
// mask. For each table entry the bench models the LFSR stream and the MISR
// fold, pushes the expected patterns to a scoreboard queue when START is
// driven, and pops and compares them whenever PAT_VALID is seen. Hand-written
// sequences then cover abort, START+ABORT in DONE and reset during RUN.
// ---------------------------------------------------------------------------
module tb_bist_ctrl;

  localparam int LAT    = 1;
  localparam int BUDGET = 700;

  logic        CLK = 1'b0;
  logic        RST;
  logic [12:0] BIST_CONF_REG;
  logic        START;
  logic        ABORT;
  logic [7:0]  EXP_SIG;
  logic [7:0]  DUT_RESP;
  logic [7:0]  PATTERN;
  logic        PAT_VALID;
  logic        BUSY;
  logic        DONE;
  logic [7:0]  SIGNATURE;
  logic        PASS;

  bist_ctrl #(.LATENCY(LAT)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .BIST_CONF_REG (BIST_CONF_REG),
    .START         (START),
    .ABORT         (ABORT),
    .EXP_SIG       (EXP_SIG),
    .DUT_RESP      (DUT_RESP),
    .PATTERN       (PATTERN),
    .PAT_VALID     (PAT_VALID),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .SIGNATURE     (SIGNATURE),
    .PASS          (PASS)
  );

  always #5 CLK = ~CLK;

  // Loopback model of the device under test.
  logic [7:0] resp_mask = 8'h00;
  logic [7:0] resp_dly  = 8'h00;
  always @(posedge CLK) resp_dly <= PATTERN ^ resp_mask;
  assign DUT_RESP = resp_dly;

  int total = 0;
  int bad   = 0;
  logic [7:0] pat_q[$];

  typedef struct {
    logic       mode;
    logic [3:0] n;
    logic [7:0] l;
    logic [7:0] mask;
    logic       scramble;   // rewrite BIST_CONF_REG during RUN
    logic       pulse;      // pulse START during RUN
    logic [7:0] exp_first;
    logic       chk_sig;
    logic [7:0] exp_sig;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] step8(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic run_test(input vec_t v);
    logic [12:0] conf;
    logic [7:0]  p, m, last;
    int          len, cyc, zeros;
    bit          first;
    conf = {v.l, v.n, v.mode};
    if (v.mode) begin
      len = (v.l == 8'd0) ? 256 : int'(v.l);
      p   = 8'h01;
    end else begin
      len = 16 * (int'(v.n) + 1);
      p   = {4'h5, v.n};
    end
    m = 8'h00;
    pat_q.delete();
    for (int i = 0; i < len; i++) begin
      pat_q.push_back(p);
      m = step8(m) ^ (p ^ v.mask);
      p = step8(p);
    end
    resp_mask     = v.mask;
    EXP_SIG       = m;
    BIST_CONF_REG = conf;
    START         = 1'b1;
    tick();
    START = 1'b0;
    check("load_busy", BUSY, 1);
    check("load_done", DONE, 0);
    check("load_pv", PAT_VALID, 0);
    cyc   = 1;
    zeros = 0;
    first = 1'b1;
    last  = 8'h00;
    while (cyc < BUDGET) begin
      tick();
      cyc++;
      if (v.scramble && cyc == 4) BIST_CONF_REG = ~conf;
      START = v.pulse && (cyc == 5 || cyc == 7);
      if (PAT_VALID) begin
        if (pat_q.size() == 0) begin
          check("pat_extra", 1, 0);
        end else begin
          check("pattern", PATTERN, pat_q.pop_front());
        end
        if (first) check("first_pat", PATTERN, v.exp_first);
        first = 1'b0;
        last  = PATTERN;
        if (PATTERN == 8'h00) zeros++;
      end
      if (DONE) break;
    end
    START = 1'b0;
    check("done_lat", cyc, len + LAT + 2);
    check("pat_left", pat_q.size(), 0);
    check("zero_pat", zeros, 0);
    check("done_busy", BUSY, 0);
    check("signature", SIGNATURE, m);
    check("pass_hi", PASS, 1);
    if (v.chk_sig) check("sig_const", SIGNATURE, v.exp_sig);
    if (v.mode && v.l == 8'd0) check("pat256", last, 8'h01);
    EXP_SIG = m ^ 8'h02;
    #1;
    check("pass_lo", PASS, 0);
    EXP_SIG = m;
    pat_q.delete();
  endtask

  initial begin
    // mode n l mask scr pulse first chk sig
    vecs[0] = '{1'b1, 4'd0,  8'd1,  8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 8'h01};
    vecs[1] = '{1'b1, 4'd0,  8'd2,  8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 8'h00};
    vecs[2] = '{1'b0, 4'd0,  8'd0,  8'h00, 1'b1, 1'b0, 8'h50, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 4'd0,  8'd0,  8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 4'd15, 8'd99, 8'h3c, 1'b0, 1'b1, 8'h5f, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 4'd9,  8'd37, 8'ha5, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 4'd3,  8'd0,  8'h81, 1'b0, 1'b0, 8'h53, 1'b0, 8'h00};

    RST           = 1'b1;
    START         = 1'b0;
    ABORT         = 1'b0;
    BIST_CONF_REG = '0;
    EXP_SIG       = 8'h00;
    tick();
    tick();
    RST = 1'b0;
    tick();
    check("rst_pattern", PATTERN, 0);
    check("rst_pv", PAT_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_sig", SIGNATURE, 0);
    check("rst_pass", PASS, 0);

    // Back-to-back: the first run starts from IDLE, the rest from DONE.
    for (int i = 0; i < 7; i++) run_test(vecs[i]);

    // START together with ABORT in DONE returns to IDLE.
    check("done_before", DONE, 1);
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    check("sa_done", DONE, 0);
    check("sa_busy", BUSY, 0);
    check("sa_pv", PAT_VALID, 0);
    tick();
    check("sa_idle", BUSY, 0);

    // ABORT on the 5th RUN cycle, followed by a clean restart.
    BIST_CONF_REG = {8'd20, 4'd0, 1'b1};
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("ab_run", PAT_VALID, 1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check("ab_pv", PAT_VALID, 0);
    check("ab_busy", BUSY, 0);
    check("ab_done", DONE, 0);
    tick();
    check("ab_idle", BUSY, 0);
    run_test(vecs[1]);

    // Reset in the middle of RUN.
    BIST_CONF_REG = {8'd50, 4'd0, 1'b1};
    START = 1'b1;
    tick();
    START = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    RST = 1'b1;
    tick();
    check("mr_pattern", PATTERN, 0);
    check("mr_pv", PAT_VALID, 0);
    check("mr_busy", BUSY, 0);
    check("mr_done", DONE, 0);
    check("mr_sig", SIGNATURE, 0);
    check("mr_pass", PASS, 0);
    RST = 1'b0;
    tick();
    check("mr_idle", BUSY, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bist_ctrl.md
# bist_ctrl

BIST sequencer for the JTAG test logic. It latches the 13-bit BIST configuration word on a start request and generates an LFSR pattern stream toward the device under test. Returned responses are compressed into an 8-bit MISR signature, which is compared against an expected value. It sits between the BIST configuration register and the DUT-facing datapath, and is started and aborted by the TAP instruction decode.

## Interface
- LATENCY, 1, cycles from a pattern being driven to its response being valid on DUT_RESP; legal 1..4
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- BIST_CONF_REG  input  13  configuration word:
  - [0] mode, 0 = preset, 1 = user
  - [4:1] preset test number N
  - [12:5] user test length L
- START  input  1  start request, sampled every cycle
- ABORT  input  1  abort request, sampled every cycle
- EXP_SIG  input  8  expected signature
- DUT_RESP  input  8  DUT response
- PATTERN  output  8  current pattern (LFSR register); meaningful only while PAT_VALID=1
- PAT_VALID  output  1  PATTERN is a live test vector this cycle
- BUSY  output  1  high in LOAD, RUN, DRAIN
- DONE  output  1  test complete, signature final
- SIGNATURE  output  8  MISR register
- PASS  output  1  DONE & (SIGNATURE == EXP_SIG), combinational

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - START=1 → LOAD.
  - BIST_CONF_REG is copied into a shadow register at the same edge.
  - Later changes to BIST_CONF_REG have no effect until the next start.
- LOAD, one cycle:
  - lfsr ← seed; misr ← 0; counter (9-bit) ← length; response-valid pipe cleared.
  - → RUN.
- Length:
  - Preset mode: 16*(N+1), range 16..256.
  - User mode: L, with L=0 meaning 256.
- Seed: preset mode {4'h5, N}; user mode 8'h01. The seed is never zero.
- RUN, once per cycle:
  - PAT_VALID=1.
  - lfsr ← {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - counter decrements.
  - When counter==1, this is the last pattern → DRAIN.
- Response capture:
  - PAT_VALID is delayed LATENCY cycles into resp_vld.
  - When resp_vld=1: misr ← {misr[6:0], misr[7]^misr[5]^misr[4]^misr[3]} ^ DUT_RESP.
- DRAIN: lasts exactly LATENCY cycles, then → DONE.
- DONE:
  - DONE=1; SIGNATURE held.
  - START=1 → LOAD (restart with a freshly latched configuration); DONE drops in LOAD.
- ABORT=1 in LOAD/RUN/DRAIN/DONE:
  - → IDLE next cycle; PAT_VALID and resp pipe cleared; DONE=0.
  - SIGNATURE keeps its partial value.
- START in LOAD/RUN/DRAIN is ignored.
- START and ABORT in the same cycle: ABORT wins.
- Reset values: state IDLE; PATTERN=0, PAT_VALID=0, BUSY=0, DONE=0, SIGNATURE=0, PASS=0; counter and resp pipe 0.

## Timing
- START sampled high at the edge ending cycle t:
  - cycle t+1: LOAD, BUSY=1.
  - cycles t+2 .. t+1+len: RUN, PAT_VALID=1, first PATTERN = seed.
  - cycles t+2+len .. t+1+len+LATENCY: DRAIN.
  - cycle t+2+len+LATENCY: DONE=1, BUSY=0.
- Total start-to-DONE latency: len + LATENCY + 2 cycles.
- Response to the pattern driven in cycle k is sampled at the edge ending cycle k+LATENCY. The last MISR update coincides with the DRAIN→DONE edge.
- PASS is valid in the first DONE cycle and tracks EXP_SIG combinationally while DONE=1.
- ABORT sampled at the edge ending cycle t: IDLE, BUSY=0, PAT_VALID=0 in cycle t+1.

## Test plan
- User mode, L=1, LATENCY=1, DUT_RESP = PATTERN delayed 1 cycle, EXP_SIG=8'h01:
  - one PAT_VALID cycle with PATTERN=8'h01.
  - DONE at t+4; SIGNATURE=8'h01; PASS=1.
  - With EXP_SIG=8'h02: PASS=0.
- User mode, L=2, same loopback:
  - PATTERN 8'h01 then 8'h02.
  - SIGNATURE=8'h00; DONE at t+5.
- Preset N=0, LATENCY=1:
  - exactly 16 PAT_VALID cycles, first PATTERN=8'h50.
  - DONE at t+19.
  - Change BIST_CONF_REG during RUN → no change in length or sequence.
- User mode, L=0:
  - 256 patterns.
  - Pattern 256 equals 8'h01 (maximal period 255); no all-zero pattern ever appears.
- ABORT on the 5th RUN cycle:
  - IDLE next cycle; PAT_VALID=0, BUSY=0, DONE=0.
  - A subsequent START runs a full clean test with MISR restarted at 0.
- START pulses during RUN are ignored. START with ABORT in DONE → IDLE. RST mid-RUN → all outputs at reset values the next cycle.
